pixel_acc_ctrl: RTL and testbench
=================================

// Module: pixel_acc_ctrl
// PURPOSE
//  Frame-level sequencer for the pixel accumulator. Accepts a "frame ready" pulse from the frame-buffer writer and drives
//  run_acc until acc_done. It then latches p_size/p_x/p_y and returns the frame buffer to the writer.
//  Computes the blob centroid (p_x/p_size, p_y/p_size) with a bit-serial divider and presents it on a valid/ready port.
//  Also reports dropped frames and accumulator timeouts.
// PARAMETERS
//  MIN_PIXELS   16'd4   minimum p_size for a valid detection; below this, no division is done and res_found=0
//  TIMEOUT_CYC  2**20   max cycles in WAIT without acc_done before abort (counter is 21 bits)
//  X_MAX        639     res_x saturation value
//  Y_MAX        479     res_y saturation value
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  frame_ready  in   1   1-cycle pulse: new frame written to the row BRAM
//  frame_release out 1   1-cycle pulse: BRAM no longer read, writer may overwrite
//  run_acc      out  1   enable to the accumulator; low holds the accumulator in reset
//  acc_done     in   1   accumulator finished (level, valid only while run_acc=1)
//  p_size       in  16   pixel count >>3
//  p_x          in  25   x-sum >>3
//  p_y          in  24   y-sum >>3
//  res_valid    out  1   result available
//  res_ready    in   1   consumer accepts the result
//  res_x        out 10   centroid x
//  res_y        out  9   centroid y
//  res_size     out 16   latched p_size
//  res_found    out  1   1 = p_size >= MIN_PIXELS and p_size != 0
//  busy         out  1   state != IDLE
//  timeout_err  out  1   sticky; set on WAIT timeout
//  drop_cnt     out  8   saturating count of rejected frame_ready pulses
//  err_clr      in   1   1-cycle pulse; clears timeout_err and drop_cnt
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset is asynchronous, so assertion mid-frame aborts immediately.
//  States are IDLE, WAIT, DIV and OUT.
//  IDLE: frame_ready=1 -> WAIT; run_acc=1 from the next cycle. The timeout counter is cleared.
//  WAIT: run_acc=1 and the counter increments each cycle.
//   - On acc_done=1, latch p_size, p_x and p_y (res_size=p_size).
//   - Next cycle: run_acc=0 and frame_release=1 for 1 cycle.
//   - Go to DIV if p_size >= MIN_PIXELS and p_size != 0. Otherwise go to OUT with res_found=0 and res_x=res_y=0.
//   - If the counter reaches TIMEOUT_CYC-1 with no acc_done: timeout_err<=1, run_acc<=0, frame_release pulse, -> IDLE.
//     No result is produced.
//   - acc_done and the timeout in the same cycle: acc_done wins.
//  DIV: two restoring dividers run in parallel, one quotient bit per cycle, MSB first.
//   - x: 25-bit dividend / 16-bit divisor. y: 24-bit dividend zero-extended to 25 bits.
//   - Exactly 25 cycles, then -> OUT with res_found=1.
//   - Quotient > X_MAX gives res_x=X_MAX; quotient > Y_MAX gives res_y=Y_MAX. Otherwise use the low bits.
//  OUT: res_valid=1. res_* are held stable until the res_valid & res_ready handshake.
//   - On handshake: res_valid<=0, -> IDLE.
//   - If frame_ready is also 1 that cycle: -> WAIT directly (run_acc=1 next cycle); the frame is not dropped.
//  Latency, with acc_done seen at cycle N:
//   - frame_release at N+1.
//   - res_valid at N+26 (found) or N+1 (not found).
//  Drops: frame_ready=1 in WAIT, DIV, or OUT without handshake -> drop_cnt+1, saturating at 255.
//  err_clr: clears timeout_err and drop_cnt; wins over a same-cycle increment or set.
//  Inputs p_* are ignored outside the acc_done cycle. acc_done outside WAIT is ignored.
// TESTING
//  1. Normal frame: acc_done after 100 cycles, p_size=100, p_x=32000, p_y=24000.
//     -> res_x=320, res_y=240, res_found=1, res_valid at N+26, frame_release at N+1.
//  2. Small blob, MIN_PIXELS=4: p_size=3, then repeat with p_size=0.
//     -> res_found=0, res_x=res_y=0, res_size=3 (then 0), res_valid at N+1. No DIV cycles.
//  3. Saturation, MIN_PIXELS=1: p_size=1, p_x=1000, p_y=1000 -> res_x=639, res_y=479, res_found=1.
//  4. Backpressure: hold res_ready=0 for 50 cycles and send 3 frame_ready pulses.
//     -> res_* stable, drop_cnt=3.
//     Then res_ready=1 with frame_ready=1 in the same cycle -> run_acc=1 next cycle, drop_cnt stays 3.
//  5. Timeout, TIMEOUT_CYC=64, acc_done never asserted:
//     -> run_acc drops after 64 WAIT cycles, timeout_err=1, one frame_release pulse, no res_valid.
//     Then err_clr -> timeout_err=0, drop_cnt=0.
//  6. Reset mid-DIV: assert rst_n=0 at DIV cycle 10.
//     -> all outputs 0 immediately, without waiting for clk. After release the block is IDLE and a new frame completes normally.

Source files
------------

// File: rtl/pixel_acc_ctrl.sv
// Frame sequencer for the pixel accumulator: runs the accumulator per frame,
// divides the latched sums by the pixel count, presents the centroid on a
// valid/ready port and reports dropped frames and accumulator timeouts.
module pixel_acc_ctrl #(
  parameter logic [15:0] MIN_PIXELS  = 16'd4,
  parameter int unsigned TIMEOUT_CYC = 2**20,
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MAX       = 479
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_ready,
  output logic        frame_release,
  output logic        run_acc,
  input  logic        acc_done,
  input  logic [15:0] p_size,
  input  logic [24:0] p_x,
  input  logic [23:0] p_y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [9:0]  res_x,
  output logic [8:0]  res_y,
  output logic [15:0] res_size,
  output logic        res_found,
  output logic        busy,
  output logic        timeout_err,
  output logic [7:0]  drop_cnt,
  input  logic        err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DIV, S_OUT} state_t;

  localparam logic [20:0] TO_LAST = 21'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  logic [15:0] dvs_q, dvs_d;
  logic [24:0] qx_q, qx_d, qy_q, qy_d;
  logic [15:0] rx_q, rx_d, ry_q, ry_d;
  logic        run_acc_q, run_acc_d;
  logic        frame_release_q, frame_release_d;
  logic        res_valid_q, res_valid_d;
  logic [9:0]  res_x_q, res_x_d;
  logic [8:0]  res_y_q, res_y_d;
  logic [15:0] res_size_q, res_size_d;
  logic        res_found_q, res_found_d;
  logic        timeout_err_q, timeout_err_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic [16:0] rx_sh, ry_sh;
  logic [15:0] rx_nxt, ry_nxt;
  logic [24:0] qx_nxt, qy_nxt;
  logic        drop_inc;

  // Restoring division step; dividend register doubles as quotient register.
  always_comb begin
    rx_sh = {rx_q, qx_q[24]};
    ry_sh = {ry_q, qy_q[24]};
    if (rx_sh >= {1'b0, dvs_q}) begin
      rx_nxt = rx_sh[15:0] - dvs_q;
      qx_nxt = {qx_q[23:0], 1'b1};
    end else begin
      rx_nxt = rx_sh[15:0];
      qx_nxt = {qx_q[23:0], 1'b0};
    end
    if (ry_sh >= {1'b0, dvs_q}) begin
      ry_nxt = ry_sh[15:0] - dvs_q;
      qy_nxt = {qy_q[23:0], 1'b1};
    end else begin
      ry_nxt = ry_sh[15:0];
      qy_nxt = {qy_q[23:0], 1'b0};
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    div_cnt_d       = div_cnt_q;
    dvs_d           = dvs_q;
    qx_d            = qx_q;
    qy_d            = qy_q;
    rx_d            = rx_q;
    ry_d            = ry_q;
    run_acc_d       = run_acc_q;
    frame_release_d = 1'b0;
    res_valid_d     = res_valid_q;
    res_x_d         = res_x_q;
    res_y_d         = res_y_q;
    res_size_d      = res_size_q;
    res_found_d     = res_found_q;
    timeout_err_d   = timeout_err_q;
    drop_cnt_d      = drop_cnt_q;
    drop_inc        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (frame_ready) begin
          state_d   = S_WAIT;
          run_acc_d = 1'b1;
          cnt_d     = '0;
        end
      end
      S_WAIT: begin
        drop_inc = frame_ready;
        cnt_d    = cnt_q + 21'd1;
        if (acc_done) begin
          run_acc_d       = 1'b0;
          frame_release_d = 1'b1;
          res_size_d      = p_size;
          dvs_d           = p_size;
          qx_d            = p_x;
          qy_d            = {1'b0, p_y};
          rx_d            = '0;
          ry_d            = '0;
          div_cnt_d       = '0;
          if (p_size >= MIN_PIXELS && p_size != 16'd0) begin
            state_d = S_DIV;
          end else begin
            state_d     = S_OUT;
            res_valid_d = 1'b1;
            res_found_d = 1'b0;
            res_x_d     = '0;
            res_y_d     = '0;
          end
        end else if (cnt_q == TO_LAST) begin
          timeout_err_d   = 1'b1;
          run_acc_d       = 1'b0;
          frame_release_d = 1'b1;
          state_d         = S_IDLE;
        end
      end
      S_DIV: begin
        drop_inc  = frame_ready;
        qx_d      = qx_nxt;
        qy_d      = qy_nxt;
        rx_d      = rx_nxt;
        ry_d      = ry_nxt;
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd24) begin
          state_d     = S_OUT;
          res_valid_d = 1'b1;
          res_found_d = 1'b1;
          res_x_d     = (qx_nxt > 25'(X_MAX)) ? 10'(X_MAX) : qx_nxt[9:0];
          res_y_d     = (qy_nxt > 25'(Y_MAX)) ? 9'(Y_MAX) : qy_nxt[8:0];
        end
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (frame_ready) begin
            state_d   = S_WAIT;
            run_acc_d = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          drop_inc = frame_ready;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (drop_inc && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;

    if (err_clr) begin
      timeout_err_d = 1'b0;
      drop_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      div_cnt_q       <= '0;
      dvs_q           <= '0;
      qx_q            <= '0;
      qy_q            <= '0;
      rx_q            <= '0;
      ry_q            <= '0;
      run_acc_q       <= 1'b0;
      frame_release_q <= 1'b0;
      res_valid_q     <= 1'b0;
      res_x_q         <= '0;
      res_y_q         <= '0;
      res_size_q      <= '0;
      res_found_q     <= 1'b0;
      timeout_err_q   <= 1'b0;
      drop_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      div_cnt_q       <= div_cnt_d;
      dvs_q           <= dvs_d;
      qx_q            <= qx_d;
      qy_q            <= qy_d;
      rx_q            <= rx_d;
      ry_q            <= ry_d;
      run_acc_q       <= run_acc_d;
      frame_release_q <= frame_release_d;
      res_valid_q     <= res_valid_d;
      res_x_q         <= res_x_d;
      res_y_q         <= res_y_d;
      res_size_q      <= res_size_d;
      res_found_q     <= res_found_d;
      timeout_err_q   <= timeout_err_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign frame_release = frame_release_q;
  assign run_acc       = run_acc_q;
  assign res_valid     = res_valid_q;
  assign res_x         = res_x_q;
  assign res_y         = res_y_q;
  assign res_size      = res_size_q;
  assign res_found     = res_found_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_err   = timeout_err_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_pixel_acc_ctrl.sv
module tb_pixel_acc_ctrl;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [15:0] size;
    logic        found;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] p_size = '0;
  logic [24:0] p_x = '0;
  logic [23:0] p_y = '0;

  logic        frame_ready = 1'b0, acc_done = 1'b0, res_ready = 1'b0, err_clr = 1'b0;
  logic        frame_release, run_acc, res_valid, res_found, busy, timeout_err;
  logic [9:0]  res_x;
  logic [8:0]  res_y;
  logic [15:0] res_size;
  logic [7:0]  drop_cnt;

  logic        t_frame_ready = 1'b0, t_acc_done = 1'b0, t_res_ready = 1'b0, t_err_clr = 1'b0;
  logic        t_frame_release, t_run_acc, t_res_valid, t_res_found, t_busy, t_timeout_err;
  logic [9:0]  t_res_x;
  logic [8:0]  t_res_y;
  logic [15:0] t_res_size;
  logic [7:0]  t_drop_cnt;

  int   checks = 0;
  int   failures = 0;
  res_t sb[$];
  res_t mon_e;

  always #5 clk = ~clk;

  pixel_acc_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready), .frame_release(frame_release),
    .run_acc(run_acc), .acc_done(acc_done), .p_size(p_size), .p_x(p_x), .p_y(p_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
    .res_size(res_size), .res_found(res_found), .busy(busy), .timeout_err(timeout_err),
    .drop_cnt(drop_cnt), .err_clr(err_clr)
  );

  pixel_acc_ctrl #(.MIN_PIXELS(16'd1), .TIMEOUT_CYC(64)) u_dut_t (
    .clk(clk), .rst_n(rst_n), .frame_ready(t_frame_ready), .frame_release(t_frame_release),
    .run_acc(t_run_acc), .acc_done(t_acc_done), .p_size(p_size), .p_x(p_x), .p_y(p_y),
    .res_valid(t_res_valid), .res_ready(t_res_ready), .res_x(t_res_x), .res_y(t_res_y),
    .res_size(t_res_size), .res_found(t_res_found), .busy(t_busy), .timeout_err(t_timeout_err),
    .drop_cnt(t_drop_cnt), .err_clr(t_err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic res_t model(input logic [15:0] s, input logic [24:0] x,
                                 input logic [23:0] y, input logic [15:0] minp);
    res_t    r;
    longint  qx, qy;
    r.size = s;
    if (s >= minp && s != 16'd0) begin
      qx      = longint'(x) / longint'(s);
      qy      = longint'(y) / longint'(s);
      r.found = 1'b1;
      r.x     = (qx > 639) ? 10'd639 : 10'(qx);
      r.y     = (qy > 479) ? 9'd479 : 9'(qy);
    end else begin
      r.found = 1'b0;
      r.x     = '0;
      r.y     = '0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("run_acc_start", 32'(run_acc), 32'd1);
    check("busy_start", 32'(busy), 32'd1);
  endtask

  task automatic finish_frame(input logic [15:0] s, input logic [24:0] x,
                              input logic [23:0] y, input int wait_cyc);
    res_t e;
    int   lat;
    e = model(s, x, y, 16'd4);
    sb.push_back(e);
    repeat (wait_cyc) tick();
    p_size = s; p_x = x; p_y = y; acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    p_size = 16'($urandom); p_x = 25'($urandom); p_y = 24'($urandom);
    check("frame_release", 32'(frame_release), 32'd1);
    check("run_acc_off", 32'(run_acc), 32'd0);
    check("res_size_latch", 32'(res_size), 32'(s));
    lat = 1;
    while (!res_valid && lat < 60) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), e.found ? 32'd26 : 32'd1);
    if (e.found) check("frame_release_pulse", 32'(frame_release), 32'd0);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_valid_clr", 32'(res_valid), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  // Scoreboard: compare every accepted result against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'(res_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_res_x", 32'(res_x), 32'(mon_e.x));
        check("sb_res_y", 32'(res_y), 32'(mon_e.y));
        check("sb_res_size", 32'(res_size), 32'(mon_e.size));
        check("sb_res_found", 32'(res_found), 32'(mon_e.found));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rel, vcnt, lat;

    repeat (3) @(posedge clk);
    #1;
    check("rst_main", 32'({frame_release, run_acc, res_valid, res_x, res_y, res_found, busy,
                          timeout_err}), 32'd0);
    check("rst_main_b", 32'({res_size, drop_cnt}), 32'd0);
    check("rst_t", 32'({t_frame_release, t_run_acc, t_res_valid, t_busy, t_timeout_err,
                       t_drop_cnt}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Normal frame.
    start_frame();
    finish_frame(16'd100, 25'd32000, 24'd24000, 99);
    handshake();

    // Small blobs and division boundaries.
    start_frame(); finish_frame(16'd3, 25'd300, 24'd300, 4);      handshake();
    start_frame(); finish_frame(16'd0, 25'd1234, 24'd55, 4);      handshake();
    start_frame(); finish_frame(16'd4, 25'd100, 24'd8, 2);        handshake();
    start_frame(); finish_frame(16'd7, 25'd4477, 24'd3000, 2);    handshake();
    start_frame(); finish_frame(16'd2, 25'd1281, 24'd959, 2);     handshake();
    start_frame(); finish_frame(16'hFFFF, 25'h1FFFFFF, 24'hFFFFFF, 2); handshake();
    check("no_drops_yet", 32'(drop_cnt), 32'd0);

    // Backpressure with drops, then accept and restart in the same cycle.
    start_frame();
    finish_frame(16'd50, 25'd5000, 24'd2000, 5);
    for (int i = 0; i < 50; i++) begin
      if (i == 5 || i == 20 || i == 40) frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      check("hold_x", 32'(res_x), 32'd100);
      check("hold_y", 32'(res_y), 32'd40);
      check("hold_valid", 32'(res_valid), 32'd1);
    end
    check("drop_cnt_3", 32'(drop_cnt), 32'd3);
    res_ready = 1'b1; frame_ready = 1'b1;
    tick();
    res_ready = 1'b0; frame_ready = 1'b0;
    check("restart_run_acc", 32'(run_acc), 32'd1);
    check("restart_drop_cnt", 32'(drop_cnt), 32'd3);
    check("restart_valid", 32'(res_valid), 32'd0);
    finish_frame(16'd64, 25'd6400, 24'd640, 10);

    // Drop counter saturation, and err_clr winning over an increment.
    frame_ready = 1'b1;
    repeat (260) tick();
    frame_ready = 1'b0;
    check("drop_sat", 32'(drop_cnt), 32'd255);
    err_clr = 1'b1; frame_ready = 1'b1;
    tick();
    err_clr = 1'b0; frame_ready = 1'b0;
    check("drop_clr_wins", 32'(drop_cnt), 32'd0);
    handshake();

    // Saturation with MIN_PIXELS=1.
    t_frame_ready = 1'b1;
    tick();
    t_frame_ready = 1'b0;
    repeat (3) tick();
    p_size = 16'd1; p_x = 25'd1000; p_y = 24'd1000; t_acc_done = 1'b1;
    tick();
    t_acc_done = 1'b0;
    check("t_release", 32'(t_frame_release), 32'd1);
    lat = 1;
    while (!t_res_valid && lat < 60) begin
      tick();
      lat++;
    end
    check("t_latency", 32'(lat), 32'd26);
    check("t_sat_x", 32'(t_res_x), 32'd639);
    check("t_sat_y", 32'(t_res_y), 32'd479);
    check("t_found", 32'(t_res_found), 32'd1);
    check("t_size", 32'(t_res_size), 32'd1);
    t_res_ready = 1'b1;
    tick();
    t_res_ready = 1'b0;
    check("t_valid_clr", 32'(t_res_valid), 32'd0);

    // Timeout with TIMEOUT_CYC=64.
    t_frame_ready = 1'b1;
    tick();
    t_frame_ready = 1'b0;
    n = 0; rel = 0; vcnt = 0;
    while (t_run_acc && n < 200) begin
      if (n == 10) t_frame_ready = 1'b1;
      tick();
      t_frame_ready = 1'b0;
      n++;
      rel += int'(t_frame_release);
      vcnt += int'(t_res_valid);
    end
    check("to_run_cycles", 32'(n), 32'd64);
    check("to_err", 32'(t_timeout_err), 32'd1);
    repeat (5) begin
      tick();
      rel += int'(t_frame_release);
      vcnt += int'(t_res_valid);
    end
    check("to_release_once", 32'(rel), 32'd1);
    check("to_no_result", 32'(vcnt), 32'd0);
    check("to_idle", 32'(t_busy), 32'd0);
    check("to_drop", 32'(t_drop_cnt), 32'd1);
    t_err_clr = 1'b1;
    tick();
    t_err_clr = 1'b0;
    check("to_err_clr", 32'(t_timeout_err), 32'd0);
    check("to_drop_clr", 32'(t_drop_cnt), 32'd0);

    // Asynchronous reset in the middle of a division.
    start_frame();
    repeat (4) tick();
    p_size = 16'd100; p_x = 25'd32000; p_y = 24'd24000; acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    repeat (10) tick();
    check("div_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 32'({frame_release, run_acc, res_valid, res_x, res_y, res_found, busy,
                           timeout_err}), 32'd0);
    check("async_rst_b", 32'({res_size, drop_cnt}), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    start_frame();
    finish_frame(16'd100, 25'd32000, 24'd24000, 20);
    handshake();

    repeat (2) tick();
    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
